// File: rtl/ahb_slave_arbiter.sv
// Per-slave AHB arbiter: round-robin grant among MASTER_NUM masters with burst
// tracking, locked-transfer support, MAX_HOLD fairness cap and data-phase owner tracking.
module ahb_slave_arbiter #(
  parameter  int MASTER_NUM = 4,
  parameter  int MAX_HOLD   = 16,
  localparam int MID_W      = $clog2(MASTER_NUM)
) (
  input  logic                  hclk,
  input  logic                  hreset_n,
  input  logic [MASTER_NUM-1:0] hreq,
  input  logic [MASTER_NUM-1:0] hlock,
  input  logic [1:0]            htrans,
  input  logic                  hready,
  output logic [MASTER_NUM-1:0] hgrant,
  output logic [MID_W-1:0]      hmaster,
  output logic [MID_W-1:0]      hmaster_data,
  output logic                  hdata_valid,
  output logic                  hmastlock
);

  localparam int         CNT_W     = $clog2(MAX_HOLD + 1);
  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GRANT = 2'd1,
    ARB_BURST = 2'd2
  } arb_state_e;

  arb_state_e            state, state_n;
  logic [MID_W-1:0]      ptr, ptr_n;
  logic [CNT_W-1:0]      beat_cnt, beat_cnt_n;
  logic [MASTER_NUM-1:0] grant_n;
  logic [MID_W-1:0]      master_n;
  logic                  lock_n;
  logic                  armed;
  logic                  rearb;
  logic                  rr_found;
  logic [MID_W-1:0]      rr_idx;
  int unsigned           cand;

  // Round-robin search starting at ptr; the current owner competes like anyone else.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    cand     = 0;
    for (int unsigned i = 0; i < MASTER_NUM; i++) begin
      cand = (32'(ptr) + i) % MASTER_NUM;
      if (!rr_found && hreq[MID_W'(cand)]) begin
        rr_found = 1'b1;
        rr_idx   = MID_W'(cand);
      end
    end
  end

  always_comb begin
    state_n    = state;
    grant_n    = hgrant;
    master_n   = hmaster;
    ptr_n      = ptr;
    beat_cnt_n = beat_cnt;
    lock_n     = hmastlock;
    rearb      = 1'b0;

    // Every grant decision is gated by hready so ownership never moves mid-wait.
    case (state)
      ARB_IDLE: begin
        if (armed && hready && (|hreq)) rearb = 1'b1;
      end
      ARB_GRANT: begin
        if (hready) begin
          if (htrans == TR_NONSEQ) state_n = ARB_BURST;
          else if ((htrans == TR_IDLE) && !hreq[hmaster]) rearb = 1'b1;
        end
      end
      ARB_BURST: begin
        if (hready) begin
          if (htrans == TR_IDLE) begin
            if (hlock[hmaster]) state_n = ARB_GRANT;
            else                rearb   = 1'b1;
          end else if ((htrans == TR_NONSEQ) && (beat_cnt >= CNT_W'(MAX_HOLD)) &&
                       !hlock[hmaster] && (|(hreq & ~hgrant))) begin
            rearb = 1'b1;
          end
        end
      end
      default: state_n = ARB_IDLE;
    endcase

    if (rearb) begin
      beat_cnt_n = '0;
      grant_n    = '0;
      master_n   = '0;
      state_n    = ARB_IDLE;
      if (rr_found) begin
        grant_n[rr_idx] = 1'b1;
        master_n        = rr_idx;
        ptr_n           = MID_W'((32'(rr_idx) + 1) % MASTER_NUM);
        state_n         = ARB_GRANT;
      end
    end else if (hready && (hgrant != '0) && htrans[1] && (beat_cnt < CNT_W'(MAX_HOLD))) begin
      beat_cnt_n = beat_cnt + CNT_W'(1);
    end

    if (hready) lock_n = (grant_n != '0) ? hlock[master_n] : 1'b0;
  end

  // armed delays the first grant after reset release by one edge.
  always_ff @(posedge hclk) begin
    if (!hreset_n) begin
      state        <= ARB_IDLE;
      hgrant       <= '0;
      hmaster      <= '0;
      hmaster_data <= '0;
      hdata_valid  <= 1'b0;
      hmastlock    <= 1'b0;
      ptr          <= '0;
      beat_cnt     <= '0;
      armed        <= 1'b0;
    end else begin
      state     <= state_n;
      hgrant    <= grant_n;
      hmaster   <= master_n;
      hmastlock <= lock_n;
      ptr       <= ptr_n;
      beat_cnt  <= beat_cnt_n;
      armed     <= 1'b1;
      if (hready) begin
        hmaster_data <= hmaster;
        hdata_valid  <= (hgrant != '0) && htrans[1];
      end
    end
  end

endmodule

// File: tb/tb_ahb_slave_arbiter.sv
// Directed self-checking bench for ahb_slave_arbiter (4 masters, MAX_HOLD 16).
module tb_ahb_slave_arbiter;

  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_NONSEQ = 2'b10;
  localparam logic [1:0] T_SEQ    = 2'b11;

  logic       hclk = 1'b0;
  logic       hreset_n;
  logic [3:0] hreq, hlock;
  logic [1:0] htrans;
  logic       hready;
  logic [3:0] hgrant;
  logic [1:0] hmaster, hmaster_data;
  logic       hdata_valid, hmastlock;

  int total = 0;
  int bad   = 0;

  always #5 hclk = ~hclk;

  ahb_slave_arbiter #(.MASTER_NUM(4), .MAX_HOLD(16)) dut (
    .hclk         (hclk),
    .hreset_n     (hreset_n),
    .hreq         (hreq),
    .hlock        (hlock),
    .htrans       (htrans),
    .hready       (hready),
    .hgrant       (hgrant),
    .hmaster      (hmaster),
    .hmaster_data (hmaster_data),
    .hdata_valid  (hdata_valid),
    .hmastlock    (hmastlock)
  );

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic do_reset();
    hreset_n = 1'b0; hreq = '0; hlock = '0; htrans = T_IDLE; hready = 1'b1;
    tick();
    hreset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    hreset_n = 1'b0; hreq = 4'b1111; hlock = '0; htrans = T_IDLE; hready = 1'b1;
    tick(); tick();
    total++; if (hgrant !== 4'b0000) begin bad++; $display("FAIL rst_hgrant got=%b exp=0000", hgrant); end
    total++; if (hmaster !== 2'd0) begin bad++; $display("FAIL rst_hmaster got=%0d exp=0", hmaster); end
    total++; if (hmaster_data !== 2'd0) begin bad++; $display("FAIL rst_hmaster_data got=%0d exp=0", hmaster_data); end
    total++; if (hdata_valid !== 1'b0) begin bad++; $display("FAIL rst_hdata_valid got=%b exp=0", hdata_valid); end
    total++; if (hmastlock !== 1'b0) begin bad++; $display("FAIL rst_hmastlock got=%b exp=0", hmastlock); end
    hreset_n = 1'b1;
    tick();
    total++; if (hgrant !== 4'b0000) begin bad++; $display("FAIL rst_release_early got=%b exp=0000", hgrant); end
    tick();
    total++; if (hgrant !== 4'b0001) begin bad++; $display("FAIL first_grant got=%b exp=0001", hgrant); end
    total++; if (hmaster !== 2'd0) begin bad++; $display("FAIL first_hmaster got=%0d exp=0", hmaster); end
  endtask

  task automatic test_rotation();
    logic [3:0] cur_g, exp_g;
    int unsigned nxt;
    // Owner keeps requesting while idle: grant is held.
    hreq = 4'b1111; htrans = T_IDLE; hready = 1'b1;
    tick();
    total++; if (hgrant !== 4'b0001) begin bad++; $display("FAIL rot_hold got=%b exp=0001", hgrant); end
    cur_g = 4'b0001;
    for (int unsigned k = 0; k < 4; k++) begin
      nxt   = (k + 1) % 4;
      exp_g = 4'b0001 << nxt;
      hreq  = 4'b1111 & ~cur_g;
      tick();
      total++; if (hgrant !== exp_g) begin bad++; $display("FAIL rot_grant[%0d] got=%b exp=%b", k, hgrant, exp_g); end
      total++; if (hmaster !== 2'(nxt)) begin bad++; $display("FAIL rot_hmaster[%0d] got=%0d exp=%0d", k, hmaster, nxt); end
      cur_g = exp_g;
    end
    // Owner M0 releases but hready low: no grant change until hready returns.
    hreq = 4'b0010; hready = 1'b0;
    tick();
    total++; if (hgrant !== 4'b0001) begin bad++; $display("FAIL nohready_hold got=%b exp=0001", hgrant); end
    hready = 1'b1;
    tick();
    total++; if (hgrant !== 4'b0010) begin bad++; $display("FAIL nohready_release got=%b exp=0010", hgrant); end
  endtask

  task automatic test_burst_wait();
    do_reset();
    hreq = 4'b0100;
    tick();
    total++; if (hgrant !== 4'b0100) begin bad++; $display("FAIL bw_grant got=%b exp=0100", hgrant); end
    hreq = 4'b1111; htrans = T_NONSEQ; hready = 1'b1;
    tick();
    htrans = T_SEQ; hready = 1'b0;
    for (int unsigned c = 0; c < 3; c++) begin
      tick();
      total++; if (hgrant !== 4'b0100) begin bad++; $display("FAIL bw_stall[%0d] got=%b exp=0100", c, hgrant); end
    end
    hready = 1'b1;
    tick(); tick(); tick();
    total++; if (hgrant !== 4'b0100) begin bad++; $display("FAIL bw_seq got=%b exp=0100", hgrant); end
    htrans = T_IDLE;
    tick();
    total++; if (hgrant !== 4'b1000) begin bad++; $display("FAIL bw_next got=%b exp=1000", hgrant); end
    total++; if (hmaster !== 2'd3) begin bad++; $display("FAIL bw_hmaster got=%0d exp=3", hmaster); end
    total++; if (hdata_valid !== 1'b0) begin bad++; $display("FAIL bw_dvalid got=%b exp=0", hdata_valid); end
  endtask

  task automatic test_lock();
    do_reset();
    hreq = 4'b0010; hlock = 4'b0010;
    tick();
    total++; if (hgrant !== 4'b0010) begin bad++; $display("FAIL lk_grant got=%b exp=0010", hgrant); end
    total++; if (hmastlock !== 1'b1) begin bad++; $display("FAIL lk_mastlock got=%b exp=1", hmastlock); end
    hreq = 4'b0011;
    htrans = T_NONSEQ; tick();
    htrans = T_SEQ; tick(); tick(); tick();
    htrans = T_IDLE; tick();
    total++; if (hgrant !== 4'b0010) begin bad++; $display("FAIL lk_idle_keep got=%b exp=0010", hgrant); end
    for (int unsigned i = 0; i < 40; i++) begin
      htrans = (i % 4 == 0) ? T_NONSEQ : T_SEQ;
      tick();
      total++; if (hgrant !== 4'b0010 || hmastlock !== 1'b1) begin
        bad++; $display("FAIL lk_beat[%0d] got=%b/%b exp=0010/1", i, hgrant, hmastlock);
      end
    end
    hlock = 4'b0000; htrans = T_IDLE;
    tick();
    total++; if (hgrant !== 4'b0001) begin bad++; $display("FAIL lk_drop got=%b exp=0001", hgrant); end
    total++; if (hmastlock !== 1'b0) begin bad++; $display("FAIL lk_drop_mastlock got=%b exp=0", hmastlock); end
  endtask

  task automatic test_max_hold();
    do_reset();
    hreq = 4'b1000;
    tick();
    total++; if (hgrant !== 4'b1000) begin bad++; $display("FAIL mh_grant got=%b exp=1000", hgrant); end
    hreq = 4'b1001; htrans = T_NONSEQ;
    for (int unsigned b = 1; b <= 16; b++) begin
      tick();
      total++; if (hgrant !== 4'b1000) begin bad++; $display("FAIL mh_beat[%0d] got=%b exp=1000", b, hgrant); end
    end
    tick();
    total++; if (hgrant !== 4'b0001) begin bad++; $display("FAIL mh_switch got=%b exp=0001", hgrant); end
    total++; if (hmaster_data !== 2'd3 || hdata_valid !== 1'b1) begin
      bad++; $display("FAIL mh_data got=%0d/%b exp=3/1", hmaster_data, hdata_valid);
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    hreq = 4'b0100; hlock = 4'b0100;
    tick();
    htrans = T_NONSEQ; tick();
    htrans = T_SEQ; tick();
    total++; if (hdata_valid !== 1'b1 || hmastlock !== 1'b1) begin
      bad++; $display("FAIL rm_pre got=%b/%b exp=1/1", hdata_valid, hmastlock);
    end
    hreset_n = 1'b0;
    tick();
    total++; if ({hgrant, hmaster, hmaster_data, hdata_valid, hmastlock} !== 10'b0) begin
      bad++; $display("FAIL rm_zero got=%b/%0d/%0d/%b/%b exp=0", hgrant, hmaster, hmaster_data, hdata_valid, hmastlock);
    end
    hreset_n = 1'b1; hlock = '0; htrans = T_IDLE; hreq = 4'b0100;
    tick();
    total++; if (hgrant !== 4'b0000) begin bad++; $display("FAIL rm_early got=%b exp=0000", hgrant); end
    tick();
    total++; if (hgrant !== 4'b0100) begin bad++; $display("FAIL rm_regrant got=%b exp=0100", hgrant); end
  endtask

  task automatic test_data_phase();
    do_reset();
    hreq = 4'b0100;
    tick();
    total++; if (hdata_valid !== 1'b0) begin bad++; $display("FAIL dp_idle got=%b exp=0", hdata_valid); end
    htrans = T_NONSEQ;
    tick();
    total++; if (hmaster_data !== 2'd2 || hdata_valid !== 1'b1) begin
      bad++; $display("FAIL dp_accept got=%0d/%b exp=2/1", hmaster_data, hdata_valid);
    end
    // Owner drops its request during the wait; grant must survive to burst end.
    htrans = T_SEQ; hready = 1'b0; hreq = 4'b1011;
    for (int unsigned c = 0; c < 3; c++) begin
      tick();
      total++; if (hmaster_data !== 2'd2 || hdata_valid !== 1'b1 || hgrant !== 4'b0100) begin
        bad++; $display("FAIL dp_wait[%0d] got=%0d/%b/%b exp=2/1/0100", c, hmaster_data, hdata_valid, hgrant);
      end
    end
    hready = 1'b1;
    tick();
    total++; if (hgrant !== 4'b0100) begin bad++; $display("FAIL dp_drop_hold got=%b exp=0100", hgrant); end
    htrans = T_IDLE;
    tick();
    total++; if (hgrant !== 4'b1000) begin bad++; $display("FAIL dp_handover got=%b exp=1000", hgrant); end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    hreset_n = 1'b0; hreq = '0; hlock = '0; htrans = T_IDLE; hready = 1'b1;
    test_reset();
    test_rotation();
    test_burst_wait();
    test_lock();
    test_max_hold();
    test_reset_mid_burst();
    test_data_phase();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
